// File: rtl/hwpe_stream_serializer_pkg.sv
// Shared types for the wide-to-narrow stream serializer: FSM state encoding
// and the lane-index width helper used to size lane counters.
package hwpe_stream_serializer_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    SERIAL = 1'b1
  } state_t;

  // Width of a lane index; at least one bit so single-bit counters stay legal.
  function automatic int unsigned lane_idx_width(input int unsigned nb_lanes);
    return (nb_lanes > 1) ? $clog2(nb_lanes) : 1;
  endfunction

endpackage

// File: rtl/hwpe_stream_lane_find_first.sv
// Priority encoder: lowest lane index >= start_i whose strobe slice is non-zero.
// start_i is one bit wider than a lane index so "one past the last lane" is representable.
module hwpe_stream_lane_find_first
  import hwpe_stream_serializer_pkg::*;
#(
  parameter int unsigned NB_LANES = 2,
  parameter int unsigned STRB_W   = 1,
  localparam int unsigned LW      = lane_idx_width(NB_LANES),
  localparam int unsigned IW      = LW + 1
) (
  input  logic [NB_LANES*STRB_W-1:0] strb_i,
  input  logic [IW-1:0]              start_i,
  output logic [LW-1:0]              idx_o,
  output logic                       found_o
);

  // Scan from the top down so the lowest qualifying lane is the one that sticks.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NB_LANES - 1; i >= 0; i--) begin
      if ((IW'(i) >= start_i) && (|strb_i[i*STRB_W +: STRB_W])) begin
        idx_o   = LW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hwpe_stream_wide_serializer.sv
// Wide-to-narrow stream serializer with a single-entry holding register, lane 0 first.
// Define HWPE_STREAM_SERIALIZER_SKIP_EMPTY_EN to skip lanes whose strobe slice is all-zero.
module hwpe_stream_wide_serializer
  import hwpe_stream_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NB_LANES   = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  // Both streams: a beat transfers on a rising edge where valid and ready are
  // both high; valid never waits on ready and payload is held while valid && !ready.
  input  logic                             push_valid_i,
  output logic                             push_ready_o,
  input  logic [DATA_WIDTH*NB_LANES-1:0]   push_data_i,
  input  logic [DATA_WIDTH*NB_LANES/8-1:0] push_strb_i,
  output logic                             pop_valid_o,
  input  logic                             pop_ready_i,
  output logic [DATA_WIDTH-1:0]            pop_data_o,
  output logic [DATA_WIDTH/8-1:0]          pop_strb_o,
  output logic                             last_o,
  output logic                             busy_o,
  output state_t                           state_o
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned LW = lane_idx_width(NB_LANES);

  state_t                         state_q, state_d;
  logic [LW-1:0]                  lane_q, lane_d;
  logic [DATA_WIDTH*NB_LANES-1:0] data_q;
  logic [SW*NB_LANES-1:0]         strb_q;
  logic                           load;
  logic                           push_hs, pop_hs;
  logic                           is_last;
  logic [LW-1:0]                  first_lane, next_lane;
  logic                           first_found;

`ifdef HWPE_STREAM_SERIALIZER_SKIP_EMPTY_EN
  localparam int unsigned IW = LW + 1;
  logic [IW-1:0] next_start;
  logic          next_found;

  assign next_start = {1'b0, lane_q} + IW'(1);

  hwpe_stream_lane_find_first #(
    .NB_LANES (NB_LANES),
    .STRB_W   (SW)
  ) i_find_first (
    .strb_i  (push_strb_i),
    .start_i ('0),
    .idx_o   (first_lane),
    .found_o (first_found)
  );

  hwpe_stream_lane_find_first #(
    .NB_LANES (NB_LANES),
    .STRB_W   (SW)
  ) i_find_next (
    .strb_i  (strb_q),
    .start_i (next_start),
    .idx_o   (next_lane),
    .found_o (next_found)
  );

  // No populated lane after the current one means this beat closes the word.
  assign is_last = !next_found;
`else
  assign first_lane  = '0;
  assign first_found = 1'b1;
  assign next_lane   = lane_q + LW'(1);
  assign is_last     = (lane_q == LW'(NB_LANES - 1));
`endif

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    load         = 1'b0;
    pop_valid_o  = (state_q == SERIAL);
    last_o       = pop_valid_o && is_last;
    // A new word may enter while the final lane of the held one leaves.
    push_ready_o = !rst_i && !clear_i &&
                   ((state_q == EMPTY) || (pop_ready_i && is_last));
    push_hs      = push_valid_i && push_ready_o;
    pop_hs       = pop_valid_o && pop_ready_i;

    if (push_hs) begin
      if (first_found) begin
        state_d = SERIAL;
        lane_d  = first_lane;
        load    = 1'b1;
      end else begin
        state_d = EMPTY;
      end
    end else if (pop_hs) begin
      if (is_last) begin
        state_d = EMPTY;
      end else begin
        lane_d = next_lane;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= EMPTY;
      lane_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (load) begin
        data_q <= push_data_i;
        strb_q <= push_strb_i;
      end
    end
  end

  assign pop_data_o = data_q[lane_q*DATA_WIDTH +: DATA_WIDTH];
  assign pop_strb_o = strb_q[lane_q*SW +: SW];
  assign busy_o     = (state_q == SERIAL);
  assign state_o    = state_q;

endmodule

// File: tb/tb_hwpe_stream_wide_serializer.sv
// Bench for hwpe_stream_wide_serializer: directed literal cases plus random traffic
// checked every cycle against a queue of expected narrow beats.
module tb_hwpe_stream_wide_serializer;
  import hwpe_stream_serializer_pkg::*;

  localparam int DW = 8;
  localparam int NB = 2;
  localparam int SW = DW / 8;
  localparam int W  = DW * NB;
  localparam int BW = 1 + SW + DW;   // expected beat = {last, strb, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, clear = 1'b0;
  logic            push_valid = 1'b0, push_ready;
  logic [W-1:0]    push_data = '0;
  logic [NB*SW-1:0] push_strb = '0;
  logic            pop_valid, pop_ready = 1'b0;
  logic [DW-1:0]   pop_data;
  logic [SW-1:0]   pop_strb;
  logic            last, busy;
  state_t          state;

  hwpe_stream_wide_serializer #(.DATA_WIDTH(DW), .NB_LANES(NB)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_data_i  (push_data),
    .push_strb_i  (push_strb),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (pop_ready),
    .pop_data_o   (pop_data),
    .pop_strb_o   (pop_strb),
    .last_o       (last),
    .busy_o       (busy),
    .state_o      (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // ---------------- scoreboard / model ----------------
  logic [BW-1:0] exp_q[$];
  logic          started = 1'b0;
  logic          exp_v, exp_r;
  logic [BW-1:0] front;

  // A held word turns into its list of narrow beats, lane 0 first.
  function automatic void append_word(input logic [W-1:0] d, input logic [NB*SW-1:0] s);
    logic keep [NB];
    int   last_l;
    last_l = -1;
    for (int l = 0; l < NB; l++) begin
`ifdef HWPE_STREAM_SERIALIZER_SKIP_EMPTY_EN
      keep[l] = |s[l*SW +: SW];
`else
      keep[l] = 1'b1;
`endif
      if (keep[l]) last_l = l;
    end
    for (int l = 0; l < NB; l++)
      if (keep[l]) exp_q.push_back({(l == last_l), s[l*SW +: SW], d[l*DW +: DW]});
  endfunction

  always @(negedge clk) begin
    exp_v = (exp_q.size() > 0);
    exp_r = !rst && !clear && ((exp_q.size() == 0) || ((exp_q.size() == 1) && pop_ready));
    if (started) begin
      chk("m_valid", pop_valid, exp_v);
      chk("m_busy", busy, exp_v);
      chk("m_state", (state == SERIAL), exp_v);
      chk("m_push_ready", push_ready, exp_r);
      if (exp_v) begin
        front = exp_q[0];
        chk("m_data", pop_data, front[DW-1:0]);
        chk("m_strb", pop_strb, front[DW +: SW]);
        chk("m_last", last, front[BW-1]);
      end else begin
        chk("m_last_idle", last, 1'b0);
      end
    end
    if (rst || clear) begin
      exp_q.delete();
    end else if (started) begin
      if (exp_v && pop_ready) void'(exp_q.pop_front());
      if (push_valid && exp_r) append_word(push_data, push_strb);
    end
    if (rst) started = 1'b1;
  end

  // ---------------- directed tables ----------------
  logic [15:0] t2_word [8] = '{16'h2211, 16'h4433, 16'h4433, 16'h6655,
                               16'h6655, 16'h0000, 16'h0000, 16'h0000};
  logic [7:0]  t2_dat  [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
  logic [7:0]  t2_pv   = 8'b0001_1111;
  logic [7:0]  t2_rdy  = 8'b1101_0101;
  logic [7:0]  t2_val  = 8'b0111_1110;
  logic [7:0]  t2_last = 8'b0101_0100;

  // ---------------- driver ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    look();
    chk("rst_push_ready", push_ready, 0);
    chk("rst_valid", pop_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", last, 0);
    chk("rst_data", pop_data, 0);
    chk("rst_strb", pop_strb, 0);
    tick();
    rst = 1'b0;
    look();
    chk("post_rst_ready", push_ready, 1);
    tick();

    // single word, both sides ready
    push_valid = 1'b1; push_data = 16'hBBAA; push_strb = 2'b11; pop_ready = 1'b1;
    look(); chk("t1_ready", push_ready, 1);
    tick(); push_valid = 1'b0;
    look(); chk("t1_v0", pop_valid, 1); chk("t1_d0", pop_data, 8'hAA); chk("t1_l0", last, 0);
    tick();
    look(); chk("t1_d1", pop_data, 8'hBB); chk("t1_l1", last, 1);
    tick();
    look(); chk("t1_idle", pop_valid, 0); chk("t1_busy", busy, 0);
    tick();

    // three back-to-back words, no bubbles
    for (int c = 0; c < 8; c++) begin
      push_valid = t2_pv[c]; push_data = t2_word[c]; push_strb = 2'b11; pop_ready = 1'b1;
      look();
      chk("t2_ready", push_ready, t2_rdy[c]);
      chk("t2_valid", pop_valid, t2_val[c]);
      if (t2_val[c]) begin
        chk("t2_data", pop_data, t2_dat[c]);
        chk("t2_last", last, t2_last[c]);
      end
      tick();
    end
    push_valid = 1'b0;

    // consumer stall holds the beat
    push_valid = 1'b1; push_data = 16'hBBAA; push_strb = 2'b11; pop_ready = 1'b0;
    look(); tick(); push_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("t3_hold_valid", pop_valid, 1); chk("t3_hold_data", pop_data, 8'hAA);
      chk("t3_hold_strb", pop_strb, 1); chk("t3_hold_last", last, 0);
      chk("t3_hold_ready", push_ready, 0);
      tick();
    end
    pop_ready = 1'b1;
    look(); chk("t3_rel_data", pop_data, 8'hAA);
    tick();
    look(); chk("t3_next_data", pop_data, 8'hBB); chk("t3_next_last", last, 1);
    tick();

    // partial strobe handling
    push_valid = 1'b1; push_data = 16'hBBAA; push_strb = 2'b10;
    look(); tick(); push_valid = 1'b0;
`ifdef HWPE_STREAM_SERIALIZER_SKIP_EMPTY_EN
    look(); chk("t4_data", pop_data, 8'hBB); chk("t4_strb", pop_strb, 1); chk("t4_last", last, 1);
    tick();
    push_valid = 1'b1; push_data = 16'h1234; push_strb = 2'b00;
    look(); chk("t4_zero_ready", push_ready, 1);
    tick(); push_valid = 1'b0;
    look(); chk("t4_zero_valid", pop_valid, 0); chk("t4_zero_busy", busy, 0);
    chk("t4_zero_ready2", push_ready, 1);
    tick();
`else
    look(); chk("t4_data0", pop_data, 8'hAA); chk("t4_strb0", pop_strb, 0); chk("t4_last0", last, 0);
    tick();
    look(); chk("t4_data1", pop_data, 8'hBB); chk("t4_strb1", pop_strb, 1); chk("t4_last1", last, 1);
    tick();
`endif

    // clear during lane 0, concurrent push refused
    push_valid = 1'b1; push_data = 16'hBBAA; push_strb = 2'b11; pop_ready = 1'b0;
    look(); tick();
    clear = 1'b1; push_data = 16'hDDCC;
    look(); chk("t5_clear_ready", push_ready, 0); chk("t5_lane0", pop_data, 8'hAA);
    tick(); clear = 1'b0; push_valid = 1'b0; pop_ready = 1'b1;
    look(); chk("t5_valid", pop_valid, 0); chk("t5_busy", busy, 0); chk("t5_ready", push_ready, 1);
    tick();
    look(); chk("t5_no_beat", pop_valid, 0);
    tick();

    // reset mid-word
    push_valid = 1'b1; push_data = 16'hBBAA; push_strb = 2'b11; pop_ready = 1'b1;
    look(); tick(); push_valid = 1'b0;
    rst = 1'b1;
    look(); chk("t6_rst_ready", push_ready, 0);
    tick(); rst = 1'b0;
    look();
    chk("t6_valid", pop_valid, 0); chk("t6_busy", busy, 0); chk("t6_last", last, 0);
    chk("t6_data", pop_data, 0); chk("t6_strb", pop_strb, 0); chk("t6_ready", push_ready, 1);
    tick();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_data  = W'($urandom());
      push_strb  = (NB*SW)'($urandom_range(0, 3));
      pop_ready  = ($urandom_range(0, 3) != 0);
      clear      = ($urandom_range(0, 59) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      tick();
    end
    push_valid = 1'b0; clear = 1'b0; rst = 1'b0; pop_ready = 1'b1;
    repeat (2 * NB + 2) tick();
    look();
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
